// File: rtl/psram_access_arbiter_if.sv
// rtl/psram_access_arbiter_if.sv - requester, memory-command and status signals of the PSRAM arbiter
interface psram_access_arbiter_if #(
  parameter int ADDR_WIDTH = 22,
  parameter int LEN_WIDTH  = 6
);
  logic                  vid_req;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic [LEN_WIDTH-1:0]  vid_len;
  logic                  vid_ack;
  logic [15:0]           vid_rdata;
  logic                  vid_rvalid;
  logic                  vid_done;

  logic                  host_req;
  logic                  host_write;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [15:0]           host_wdata;
  logic                  host_ack;
  logic [15:0]           host_rdata;
  logic                  host_rvalid;
  logic                  host_done;

  logic                  mem_cmd_valid;
  logic                  mem_cmd_ready;
  logic                  mem_cmd_write;
  logic [ADDR_WIDTH-1:0] mem_cmd_addr;
  logic [LEN_WIDTH-1:0]  mem_cmd_len;
  logic [15:0]           mem_cmd_wdata;
  logic [15:0]           mem_rdata;
  logic                  mem_rvalid;
  logic                  mem_done;

  logic                  xfer_err;

  // master: the arbiter itself; slave: requesters plus PSRAM controller
  modport master (
    input  vid_req, vid_addr, vid_len,
    output vid_ack, vid_rdata, vid_rvalid, vid_done,
    input  host_req, host_write, host_addr, host_wdata,
    output host_ack, host_rdata, host_rvalid, host_done,
    output mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len, mem_cmd_wdata,
    input  mem_cmd_ready, mem_rdata, mem_rvalid, mem_done,
    output xfer_err
  );

  modport slave (
    output vid_req, vid_addr, vid_len,
    input  vid_ack, vid_rdata, vid_rvalid, vid_done,
    output host_req, host_write, host_addr, host_wdata,
    input  host_ack, host_rdata, host_rvalid, host_done,
    input  mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len, mem_cmd_wdata,
    output mem_cmd_ready, mem_rdata, mem_rvalid, mem_done,
    input  xfer_err
  );
endinterface

// File: rtl/psram_access_arbiter.sv
// rtl/psram_access_arbiter.sv - video-priority arbiter for the PSRAM command port with host starvation limit
module psram_access_arbiter #(
  parameter int ADDR_WIDTH     = 22,
  parameter int LEN_WIDTH      = 6,
  parameter int VID_STREAK_MAX = 4
) (
  input logic                  clock,
  input logic                  reset,
  psram_access_arbiter_if.master bus
);
  localparam int SW = $clog2(VID_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(VID_STREAK_MAX);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                state, state_next;
  logic                  grant_vid, grant_host;
  logic [SW-1:0]         streak;
  logic                  owner_vid;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [15:0]           cmd_wdata;
  logic [LEN_WIDTH-1:0]  vid_cnt, cnt_final;
  logic [15:0]           vid_rdata_q, host_rdata_q;
  logic                  vid_rvalid_q, host_rvalid_q;
  logic                  vid_done_q, host_done_q;
  logic                  err_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    grant_vid  = 1'b0;
    grant_host = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        grant_vid  = bus.vid_req && (!bus.host_req || streak < STREAK_MAX);
        grant_host = !grant_vid && bus.host_req;
        if (grant_vid || grant_host) state_next = CMD;
      end
      CMD:  if (bus.mem_cmd_ready) state_next = DATA;
      DATA: if (bus.mem_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A word arriving together with mem_done still counts toward the length check.
  assign cnt_final = vid_cnt + LEN_WIDTH'(bus.mem_rvalid);

  always_ff @(posedge clock) begin
    if (reset) begin
      streak        <= '0;
      owner_vid     <= 1'b0;
      cmd_write     <= 1'b0;
      cmd_addr      <= '0;
      cmd_len       <= '0;
      cmd_wdata     <= '0;
      vid_cnt       <= '0;
      vid_rdata_q   <= '0;
      host_rdata_q  <= '0;
      vid_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      vid_done_q    <= 1'b0;
      host_done_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      vid_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      vid_done_q    <= 1'b0;
      host_done_q   <= 1'b0;
      if (state == IDLE) begin
        if (grant_vid) begin
          owner_vid <= 1'b1;
          cmd_write <= 1'b0;
          cmd_addr  <= bus.vid_addr;
          cmd_len   <= bus.vid_len;
          cmd_wdata <= '0;
          vid_cnt   <= '0;
        end else if (grant_host) begin
          owner_vid <= 1'b0;
          cmd_write <= bus.host_write;
          cmd_addr  <= bus.host_addr;
          cmd_len   <= LEN_WIDTH'(1);
          cmd_wdata <= bus.host_wdata;
        end
        if (grant_host || !bus.host_req) streak <= '0;
        else if (grant_vid && streak != STREAK_MAX) streak <= streak + 1'b1;
      end
      if (state == DATA) begin
        if (bus.mem_rvalid) begin
          if (owner_vid) begin
            vid_rdata_q  <= bus.mem_rdata;
            vid_rvalid_q <= 1'b1;
            vid_cnt      <= cnt_final;
          end else begin
            host_rdata_q  <= bus.mem_rdata;
            host_rvalid_q <= 1'b1;
          end
        end
        if (bus.mem_done) begin
          if (owner_vid) begin
            vid_done_q <= 1'b1;
            if (cnt_final != cmd_len) err_q <= 1'b1;
          end else begin
            host_done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.mem_cmd_valid = (state == CMD);
  assign bus.mem_cmd_write = cmd_write;
  assign bus.mem_cmd_addr  = cmd_addr;
  assign bus.mem_cmd_len   = cmd_len;
  assign bus.mem_cmd_wdata = cmd_wdata;
  assign bus.vid_ack       = (state == CMD) && owner_vid && bus.mem_cmd_ready;
  assign bus.host_ack      = (state == CMD) && !owner_vid && bus.mem_cmd_ready;
  assign bus.vid_rdata     = vid_rdata_q;
  assign bus.vid_rvalid    = vid_rvalid_q;
  assign bus.vid_done      = vid_done_q;
  assign bus.host_rdata    = host_rdata_q;
  assign bus.host_rvalid   = host_rvalid_q;
  assign bus.host_done     = host_done_q;
  assign bus.xfer_err      = err_q;
endmodule

// File: doc/psram_access_arbiter.md
# psram_access_arbiter

Shares the single command port of the on-board QSPI PSRAM controller between two requesters: the video line-fetch engine (burst reads feeding the scan-out path toward the DVI encoder) and a host port (single-word reads/writes for drawing and configuration). Video gets priority, bounded by a starvation limit that guarantees host service. The block sits between the requesters and the PSRAM controller, in the `clock` (pixel clock) domain.

## Interface
Parameters:
- `ADDR_WIDTH`, 22, word (16-bit) address width; 22 bits covers 8 MB.
- `LEN_WIDTH`, 6, width of the burst-length field; length value 0 is illegal.
- `VID_STREAK_MAX`, 4, maximum consecutive video grants while `host_req` is pending.

Ports:
- `clock`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `vid_req`  in  1  video request, level; held until `vid_ack`.
- `vid_addr`  in  ADDR_WIDTH  burst start word address.
- `vid_len`  in  LEN_WIDTH  burst length in words, 1..2^LEN_WIDTH-1.
- `vid_ack`  out  1  command accepted by memory (combinational).
- `vid_rdata`  out  16  read data.
- `vid_rvalid`  out  1  `vid_rdata` valid.
- `vid_done`  out  1  one-cycle pulse at end of video transaction.
- `host_req`  in  1  host request, level; held until `host_ack`.
- `host_write`  in  1  1 = write, 0 = read.
- `host_addr`  in  ADDR_WIDTH  word address.
- `host_wdata`  in  16  write data.
- `host_ack`  out  1  command accepted (combinational).
- `host_rdata`  out  16  read data.
- `host_rvalid`  out  1  `host_rdata` valid.
- `host_done`  out  1  one-cycle pulse at end of host transaction.
- `mem_cmd_valid`  out  1  command valid to controller.
- `mem_cmd_ready`  in  1  controller accepts the command.
- `mem_cmd_write`  out  1  write command.
- `mem_cmd_addr`  out  ADDR_WIDTH  command address.
- `mem_cmd_len`  out  LEN_WIDTH  command length in words.
- `mem_cmd_wdata`  out  16  write data.
- `mem_rdata`  in  16  read data from controller.
- `mem_rvalid`  in  1  `mem_rdata` valid.
- `mem_done`  in  1  controller finished the current transaction.
- `xfer_err`  out  1  sticky: a video read returned a word count different from `vid_len`.

## Operation
States: IDLE, CMD, DATA. `owner` register: VID or HOST.

IDLE, grant decision:
- Video is granted if `vid_req` is high and either `host_req`=0 or `streak` < `VID_STREAK_MAX`.
- Otherwise host is granted if `host_req` is high.
- With no request, the block stays in IDLE.

On grant:
- Latch `owner`, address, length, write flag and wdata into the mem_cmd_* registers, then go to CMD.
- Host commands always use length 1.
- Video commands always have write = 0.

`streak` counter:
- Increments (saturating at `VID_STREAK_MAX`) on a video grant while `host_req`=1.
- Clears on any host grant, and clears in IDLE when `host_req`=0.

CMD:
- `mem_cmd_valid`=1, with all fields stable until handshake.
- On `mem_cmd_valid & mem_cmd_ready`: the owner's ack is high in that same cycle, then go to DATA.

DATA:
- Each `mem_rvalid` is steered to the owner's rdata/rvalid, registered with 1-cycle latency. The non-owner's rvalid stays 0.
- The video read-word counter increments per `mem_rvalid`.
- On `mem_done`: the owner's done pulses in the next cycle and the state returns to IDLE in the next cycle. If owner=VID and the final word count (including an `mem_rvalid` in the same cycle as `mem_done`) ≠ latched length, `xfer_err` is set.
- `mem_rvalid` outside DATA is ignored.
- Host writes: the controller issues `mem_done` without `mem_rvalid`, which is legal.

Reset:
- Values: state=IDLE, `streak`=0, `mem_cmd_valid`=0, all rvalid/done/ack=0, rdata=0, `xfer_err`=0, cmd fields=0.
- Reset mid-transaction abandons it with no done pulse. The PSRAM controller shares the same reset.

## Timing
- Grant latency: request sampled in IDLE at edge n; `mem_cmd_valid` high from cycle n+1.
- Ack is combinational, so a requester sees ack in the handshake cycle and drops req on the next edge. Because the return to IDLE is ≥1 cycle after ack, a stale req is never regranted.
- Read data: `mem_rvalid` at cycle k gives owner rvalid at k+1.
- Done: `mem_done` at cycle d gives owner done at d+1 and state IDLE at d+1. The earliest next `mem_cmd_valid` is d+2.
- Minimum turnaround with `mem_cmd_ready` tied high and a one-word transaction: 4 cycles from request to done pulse.

## Test plan
- Single host write (addr 0x000123, data 0xA55A, ready tied 1): `mem_cmd_valid` 1 cycle after req with write=1 and len=1; `host_ack` in the same cycle; `host_done` 1 cycle after `mem_done`; `vid_*` outputs stay 0.
- Video burst with len=16 and `mem_cmd_ready` delayed 3 cycles: command fields stable throughout the wait; 16 `vid_rvalid` pulses, each 1 cycle after `mem_rvalid`, with matching data; `vid_done` pulses once; `xfer_err`=0.
- Both requesting continuously with `VID_STREAK_MAX`=4: grant order is V,V,V,V,H,V,V,V,V,H.
- Short burst: `vid_len`=8, controller returns 7 words then `mem_done`: `xfer_err` goes to 1 and stays 1 through following clean transactions until `reset`.
- `mem_rvalid` and `mem_done` in the same cycle on the last word: the word is forwarded and counted; `xfer_err`=0.
- Assert `reset` for 1 cycle while in CMD and again while in DATA: the next cycle shows all outputs at reset values with no done pulse, and a subsequent host request is served normally.
